// File: rtl/awmc_actuator_drive.sv
// Actuator drive for the washing-machine sequencer: ramped PWM motor, interlocked
// inlet valve / drain pump with dead time, and an end-of-cycle buzzer pattern.
module awmc_actuator_drive #(
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned WASH_DUTY  = 96,
    parameter int unsigned RINSE_DUTY = 64,
    parameter int unsigned SPIN_DUTY  = 240,
    parameter int unsigned RAMP_DIV   = 4,
    parameter int unsigned DEAD_CYC   = 2,
    parameter int unsigned BEEP_ON    = 4,
    parameter int unsigned BEEP_OFF   = 4,
    parameter int unsigned BEEP_COUNT = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          stage_i,
    input  logic                valve_req,
    input  logic                drain_req,
    input  logic                done_i,
    output logic                motor_pwm,
    output logic [PWM_BITS-1:0] motor_duty,
    output logic                valve_o,
    output logic                drain_o,
    output logic                buzzer,
    output logic                busy
);
    localparam int unsigned BeepPer = BEEP_ON + BEEP_OFF;
    localparam int unsigned RampW   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned DeadW   = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam int unsigned PhW     = (BeepPer > 1) ? $clog2(BeepPer) : 1;
    localparam int unsigned NumW    = (BEEP_COUNT > 1) ? $clog2(BEEP_COUNT) : 1;

    localparam logic [RampW-1:0] RampLast = RampW'(RAMP_DIV - 1);
    localparam logic [DeadW-1:0] DeadLast = DeadW'(DEAD_CYC - 1);
    localparam logic [PhW-1:0]   PhLast   = PhW'(BeepPer - 1);
    localparam logic [PhW-1:0]   OnLast   = PhW'(BEEP_ON - 1);
    localparam logic [NumW-1:0]  NumLast  = NumW'(BEEP_COUNT - 1);

    localparam logic [2:0] StageWash  = 3'b001;
    localparam logic [2:0] StageRinse = 3'b010;
    localparam logic [2:0] StageSpin  = 3'b011;
    localparam logic [2:0] StageStop  = 3'b100;
    localparam logic [2:0] StageIdle  = 3'b111;

    // ---------------- Motor duty ramp and PWM ----------------
    logic [PWM_BITS-1:0] target;
    logic [PWM_BITS-1:0] duty_d;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [RampW-1:0]    presc;

    always_comb begin
        unique case (stage_i)
            StageWash:  target = PWM_BITS'(WASH_DUTY);
            StageRinse: target = PWM_BITS'(RINSE_DUTY);
            StageSpin:  target = PWM_BITS'(SPIN_DUTY);
            default:    target = '0;
        endcase
    end

    // IDLE is a pause: duty drops straight to 0 without ramping.
    always_comb begin
        duty_d = motor_duty;
        if (stage_i == StageIdle) begin
            duty_d = '0;
        end else if (presc == RampLast) begin
            if (motor_duty < target) begin
                duty_d = motor_duty + 1'b1;
            end else if (motor_duty > target) begin
                duty_d = motor_duty - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            motor_duty <= '0;
            presc      <= '0;
            pwm_cnt    <= '0;
            motor_pwm  <= 1'b0;
        end else begin
            motor_duty <= duty_d;
            presc      <= (stage_i == StageIdle || presc == RampLast) ? '0 : presc + 1'b1;
            pwm_cnt    <= pwm_cnt + 1'b1;
            motor_pwm  <= (pwm_cnt < motor_duty);
        end
    end

    // ---------------- Valve / drain interlock ----------------
    typedef enum logic [1:0] {StOff, StFilling, StDraining, StDead} il_state_e;

    il_state_e        il_state;
    il_state_e        off_pick;
    logic [DeadW-1:0] dead_cnt;
    logic             valve_eff;
    logic             dead_last;
    logic             fsm_active_d;

    assign valve_eff = valve_req & (stage_i != StageIdle) & (stage_i != StageStop);
    assign dead_last = (dead_cnt == DeadLast);

    always_comb begin
        off_pick = StOff;
        if (drain_req) begin
            off_pick = StDraining;
        end else if (valve_eff) begin
            off_pick = StFilling;
        end
        fsm_active_d = 1'b1;
        if (il_state == StOff || (il_state == StDead && dead_last)) begin
            fsm_active_d = (off_pick != StOff);
        end
    end

    // The last dead-time cycle applies the OFF decision directly so the gap is exactly DEAD_CYC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            il_state <= StOff;
            dead_cnt <= '0;
            valve_o  <= 1'b0;
            drain_o  <= 1'b0;
        end else begin
            unique case (il_state)
                StOff, StDead: begin
                    if (il_state == StOff || dead_last) begin
                        il_state <= off_pick;
                        valve_o  <= (off_pick == StFilling);
                        drain_o  <= (off_pick == StDraining);
                    end else begin
                        dead_cnt <= dead_cnt + 1'b1;
                    end
                end
                StFilling: begin
                    if (!valve_eff || drain_req) begin
                        il_state <= StDead;
                        dead_cnt <= '0;
                        valve_o  <= 1'b0;
                    end
                end
                StDraining: begin
                    if (!drain_req) begin
                        il_state <= StDead;
                        dead_cnt <= '0;
                        drain_o  <= 1'b0;
                    end
                end
                default: begin
                    il_state <= StOff;
                    valve_o  <= 1'b0;
                    drain_o  <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- Buzzer pattern ----------------
    logic            done_prev;
    logic            done_rise;
    logic            beep_active;
    logic            beep_active_d;
    logic            beep_end;
    logic [PhW-1:0]  beep_ph;
    logic [NumW-1:0] beep_num;

    assign done_rise     = done_i & ~done_prev;
    assign beep_end      = beep_active & (beep_ph == PhLast) & (beep_num == NumLast);
    assign beep_active_d = done_rise | (beep_active & ~beep_end);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_prev   <= 1'b0;
            beep_active <= 1'b0;
            beep_ph     <= '0;
            beep_num    <= '0;
            buzzer      <= 1'b0;
        end else begin
            done_prev   <= done_i;
            beep_active <= beep_active_d;
            if (done_rise) begin
                beep_ph  <= '0;
                beep_num <= '0;
                buzzer   <= 1'b1;
            end else if (beep_active) begin
                if (beep_ph == PhLast) begin
                    beep_ph  <= '0;
                    beep_num <= beep_num + 1'b1;
                    buzzer   <= ~beep_end;
                end else begin
                    beep_ph <= beep_ph + 1'b1;
                    buzzer  <= (beep_ph < OnLast);
                end
            end
        end
    end

    // busy is built from next-state values so it lines up with the outputs it summarises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
        end else begin
            busy <= (duty_d != '0) | fsm_active_d | beep_active_d;
        end
    end

endmodule

// File: tb/tb_awmc_actuator_drive.sv
// Self-checking bench for awmc_actuator_drive: directed scenarios plus randomized
// stimulus, all compared against a behavioural model of the actuator rules.
module tb_awmc_actuator_drive;
    localparam int RampDiv   = 4;
    localparam int DeadCyc   = 2;
    localparam int BeepOn    = 4;
    localparam int BeepOff   = 4;
    localparam int BeepCount = 3;
    localparam int BeepLen   = (BeepOn + BeepOff) * BeepCount;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] stage_i = 3'b111;
    logic       valve_req = 1'b0;
    logic       drain_req = 1'b0;
    logic       done_i = 1'b0;
    logic       motor_pwm;
    logic [7:0] motor_duty;
    logic       valve_o;
    logic       drain_o;
    logic       buzzer;
    logic       busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    awmc_actuator_drive #(
        .PWM_BITS  (8),
        .WASH_DUTY (96),
        .RINSE_DUTY(64),
        .SPIN_DUTY (240),
        .RAMP_DIV  (RampDiv),
        .DEAD_CYC  (DeadCyc),
        .BEEP_ON   (BeepOn),
        .BEEP_OFF  (BeepOff),
        .BEEP_COUNT(BeepCount)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stage_i   (stage_i),
        .valve_req (valve_req),
        .drain_req (drain_req),
        .done_i    (done_i),
        .motor_pwm (motor_pwm),
        .motor_duty(motor_duty),
        .valve_o   (valve_o),
        .drain_o   (drain_o),
        .buzzer    (buzzer),
        .busy      (busy)
    );

    // Behavioural model: mode 0=off 1=filling 2=draining 3=dead; m_since = cycles since done rose.
    int m_duty = 0, m_tick = 0, m_cnt = 0, m_mode = 0, m_gap = 0, m_since = BeepLen;
    bit m_pwm = 0, m_valve = 0, m_drain = 0, m_buzz = 0, m_busy = 0, m_prev = 0;

    always @(posedge clk or posedge reset) begin : model
        int tgt;
        bit v;
        if (reset) begin
            m_duty = 0; m_tick = 0; m_cnt = 0; m_mode = 0; m_gap = 0; m_since = BeepLen;
            m_pwm = 0; m_valve = 0; m_drain = 0; m_buzz = 0; m_busy = 0; m_prev = 0;
        end else begin
            case (stage_i)
                3'd1:    tgt = 96;
                3'd2:    tgt = 64;
                3'd3:    tgt = 240;
                default: tgt = 0;
            endcase
            m_pwm = (m_cnt < m_duty);
            m_cnt = (m_cnt + 1) % 256;
            if (stage_i == 3'd7) begin
                m_duty = 0;
                m_tick = 0;
            end else begin
                m_tick++;
                if (m_tick == RampDiv) begin
                    m_tick = 0;
                    if (m_duty < tgt) m_duty++;
                    else if (m_duty > tgt) m_duty--;
                end
            end
            v = valve_req && stage_i != 3'd7 && stage_i != 3'd4;
            case (m_mode)
                0: m_mode = drain_req ? 2 : (v ? 1 : 0);
                1: if (!v || drain_req) begin m_mode = 3; m_gap = DeadCyc; end
                2: if (!drain_req) begin m_mode = 3; m_gap = DeadCyc; end
                default: begin
                    m_gap--;
                    if (m_gap == 0) m_mode = drain_req ? 2 : (v ? 1 : 0);
                end
            endcase
            m_valve = (m_mode == 1);
            m_drain = (m_mode == 2);
            if (done_i && !m_prev) m_since = 0;
            else if (m_since < BeepLen) m_since++;
            m_prev = done_i;
            m_buzz = (m_since < BeepLen) && ((m_since % (BeepOn + BeepOff)) < BeepOn);
            m_busy = (m_duty != 0) || (m_mode != 0) || (m_since < BeepLen);
        end
    end

    logic [12:0] dut_vec, model_vec;
    assign dut_vec   = {motor_pwm, motor_duty, valve_o, drain_o, buzzer, busy};
    assign model_vec = {m_pwm, 8'(m_duty), m_valve, m_drain, m_buzz, m_busy};

    task automatic test_reset();
        stage_i = 3'b111; valve_req = 0; drain_req = 0; done_i = 0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (dut_vec !== 13'd0) begin
            fails++; $display("FAIL reset_outputs: got %h want 0", dut_vec);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (dut_vec !== model_vec) begin
                fails++; $display("FAIL reset_idle cyc %0d: got %h want %h", i, dut_vec, model_vec);
            end
        end
    endtask

    task automatic test_wash_ramp();
        int hi = 0;
        stage_i = 3'b001;
        for (int i = 0; i < 384; i++) begin
            @(negedge clk);
            tests++;
            if (dut_vec !== model_vec || motor_duty !== 8'((i + 1) / RampDiv)) begin
                fails++; $display("FAIL wash_ramp cyc %0d: got %h want %h", i, dut_vec, model_vec);
            end
        end
        tests++;
        if (motor_duty !== 8'd96) begin
            fails++; $display("FAIL wash_reach: duty %0d want 96", motor_duty);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tests++;
            if (motor_duty !== 8'd96 || dut_vec !== model_vec) begin
                fails++; $display("FAIL wash_hold cyc %0d: got %h want %h", i, dut_vec, model_vec);
            end
        end
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            hi += int'(motor_pwm);
        end
        tests++;
        if (hi != 96) begin
            fails++; $display("FAIL wash_pwm_highs: got %0d want 96", hi);
        end
    endtask

    task automatic test_idle_pause();
        stage_i = 3'b111;
        @(negedge clk);
        tests++;
        if (motor_duty !== 8'd0) begin
            fails++; $display("FAIL idle_duty: got %0d want 0", motor_duty);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tests++;
            if (motor_pwm !== 1'b0 || dut_vec !== model_vec) begin
                fails++; $display("FAIL idle_pwm cyc %0d: got %h want %h", i, dut_vec, model_vec);
            end
        end
    endtask

    task automatic test_spin_stop();
        stage_i = 3'b001;
        repeat (384) @(negedge clk);
        tests++;
        if (motor_duty !== 8'd96) begin
            fails++; $display("FAIL spin_pre: duty %0d want 96", motor_duty);
        end
        stage_i = 3'b011;
        for (int i = 0; i < 576; i++) begin
            @(negedge clk);
            tests++;
            if (motor_duty !== 8'(96 + (i + 1) / RampDiv) || dut_vec !== model_vec) begin
                fails++; $display("FAIL spin_up cyc %0d: got %h want %h", i, dut_vec, model_vec);
            end
        end
        stage_i = 3'b100;
        for (int i = 0; i < 960; i++) begin
            @(negedge clk);
            tests++;
            if (motor_duty !== 8'(240 - (i + 1) / RampDiv) || dut_vec !== model_vec) begin
                fails++; $display("FAIL stop_down cyc %0d: got %h want %h", i, dut_vec, model_vec);
            end
        end
    endtask

    task automatic test_fill_to_drain();
        int  gap = 0;
        bit  seen = 0;
        stage_i = 3'b000; valve_req = 1; drain_req = 0;
        repeat (3) @(negedge clk);
        tests++;
        if (valve_o !== 1'b1 || drain_o !== 1'b0 || dut_vec !== model_vec) begin
            fails++; $display("FAIL fill_open: got %h want %h", dut_vec, model_vec);
        end
        drain_req = 1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            tests++;
            if ((valve_o & drain_o) !== 1'b0 || dut_vec !== model_vec ||
                (i == 0 && valve_o !== 1'b0)) begin
                fails++; $display("FAIL fill_drain cyc %0d: got %h want %h", i, dut_vec, model_vec);
            end
            if (drain_o) seen = 1;
            else if (!valve_o) gap++;
        end
        tests++;
        if (!seen || gap != DeadCyc) begin
            fails++; $display("FAIL dead_gap: got %0d (drain seen %0d) want %0d", gap, seen, DeadCyc);
        end
        valve_req = 0; drain_req = 0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_both_and_stop();
        stage_i = 3'b000; valve_req = 1; drain_req = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (drain_o !== 1'b1 || valve_o !== 1'b0 || dut_vec !== model_vec) begin
                fails++; $display("FAIL both_req cyc %0d: got %h want %h", i, dut_vec, model_vec);
            end
        end
        valve_req = 0; drain_req = 0;
        repeat (4) @(negedge clk);
        stage_i = 3'b100; valve_req = 1;
        for (int i = 0; i < 10; i++) begin
            if (i == 6) stage_i = 3'b111;
            @(negedge clk);
            tests++;
            if (valve_o !== 1'b0 || dut_vec !== model_vec) begin
                fails++; $display("FAIL masked_valve cyc %0d: got %h want %h", i, dut_vec, model_vec);
            end
        end
        stage_i = 3'b000;
        @(negedge clk);
        tests++;
        if (valve_o !== 1'b1) begin
            fails++; $display("FAIL fill_unmask: valve %b want 1", valve_o);
        end
        stage_i = 3'b100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (valve_o !== 1'b0 || dut_vec !== model_vec) begin
                fails++; $display("FAIL stop_close cyc %0d: got %h want %h", i, dut_vec, model_vec);
            end
        end
        valve_req = 0; stage_i = 3'b111;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_buzzer();
        for (int pass = 0; pass < 2; pass++) begin
            int  hi = 0, rises = 0;
            bit  prevb = 0;
            if (pass == 1) begin
                done_i = 0; @(negedge clk); done_i = 1;
                repeat (10) @(negedge clk);
                done_i = 0; @(negedge clk);
            end
            done_i = 1;
            for (int i = 0; i < BeepLen + 10; i++) begin
                @(negedge clk);
                tests++;
                if (dut_vec !== model_vec || busy !== (i < BeepLen) ||
                    (i == 0 && buzzer !== 1'b1)) begin
                    fails++;
                    $display("FAIL beep p%0d cyc %0d: got %h want %h", pass, i, dut_vec, model_vec);
                end
                if (buzzer && !prevb) rises++;
                hi += int'(buzzer);
                prevb = buzzer;
            end
            tests++;
            if (rises != BeepCount || hi != BeepOn * BeepCount) begin
                fails++; $display("FAIL beep_count p%0d: beeps %0d highs %0d want 3/12", pass, rises, hi);
            end
        end
        done_i = 0;
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            tests++;
            if ((valve_o & drain_o) !== 1'b0 || dut_vec !== model_vec) begin
                fails++; $display("FAIL random cyc %0d: got %h want %h", i, dut_vec, model_vec);
            end
            if ($urandom_range(0, 63) == 0) stage_i = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) valve_req = ~valve_req;
            if ($urandom_range(0, 23) == 0) drain_req = ~drain_req;
            if ($urandom_range(0, 39) == 0) done_i = ~done_i;
        end
    endtask

    task automatic test_reset_midop();
        stage_i = 3'b011; valve_req = 1; drain_req = 0; done_i = 0;
        @(negedge clk); done_i = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tests++;
            if (dut_vec !== model_vec) begin
                fails++; $display("FAIL midop_run cyc %0d: got %h want %h", i, dut_vec, model_vec);
            end
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if (dut_vec !== 13'd0) begin
            fails++; $display("FAIL midop_reset: got %h want 0", dut_vec);
        end
        @(negedge clk);
        reset = 1'b0; stage_i = 3'b111; valve_req = 0; done_i = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (dut_vec !== model_vec) begin
                fails++; $display("FAIL midop_after cyc %0d: got %h want %h", i, dut_vec, model_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_wash_ramp();
        test_idle_pause();
        test_spin_stop();
        test_fill_to_drain();
        test_both_and_stop();
        test_buzzer();
        test_random();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
